demux_rr_scheduler: RTL and testbench

//  Round-robin scheduler for the 1-to-4 tristate demux datapath. Takes a word stream on a

---
 rtl/demux_sched_pkg.sv | 22 ++
 rtl/demux_rr_scheduler_rr_pick4.sv | 40 ++++
 rtl/demux_rr_scheduler.sv | 153 +++++++++++++++
 tb/tb_demux_rr_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_sched_pkg
//  Purpose  : Shared types and constants for the 1-to-4 demux round-robin
//             scheduler: channel count, FSM state encoding, grant index type.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package demux_sched_pkg;

    localparam int NCH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        XFER = 2'd2
    } state_t;

    typedef logic [1:0] grant_t;

endpackage : demux_sched_pkg
`default_nettype wire

// File: rtl/demux_rr_scheduler_rr_pick4.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick4
//  Purpose  : Combinational round-robin picker. Scans mask starting one
//             position after `last`, wrapping 3 -> 0, and returns the first
//             eligible channel.
//  Ports    : mask  in  [3:0]  eligible channels
//             last  in  [1:0]  previously served channel
//             idx   out [1:0]  chosen channel (0 when nothing found)
//             found out        at least one channel eligible
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick4
    import demux_sched_pkg::*;
(
    input  logic [NCH-1:0] mask,
    input  grant_t         last,
    output grant_t         idx,
    output logic           found
);

    grant_t w_cand;

    // Offsets 1..4 from last; offset 4 wraps back onto last itself so a lone
    // eligible channel is re-granted.
    always_comb begin
        idx    = '0;
        found  = 1'b0;
        w_cand = '0;
        for (int k = 1; k <= NCH; k++) begin
            w_cand = last + grant_t'(k);
            if (!found && mask[w_cand]) begin
                idx   = w_cand;
                found = 1'b1;
            end
        end
    end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/demux_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : demux_rr_scheduler
//  Purpose  : Buffers one producer word and offers it to one of 4 consumers
//             in round-robin order, driving the tristate demux select and
//             enable. A channel that stalls for TIMEOUT cycles is skipped and
//             the word is re-offered to the next eligible channel.
//  Ports    : clk, rst_n          clock, async active-low reset
//             ch_mask  in  [3:0]  channel eligibility (sampled in ARB)
//             in_valid/in_data/in_ready   producer handshake
//             ch_ready in  [3:0]  consumer ready
//             ch_valid out [3:0]  one-hot valid to granted channel
//             ch_data  out [W]    buffered word
//             sel/en   out        demux select / data enable
//             busy     out        scheduler not idle
//             skip_cnt out [CNT_W] saturating timeout-skip count
//  Revision : 1.0 - initial release
// ============================================================================
module demux_rr_scheduler
    import demux_sched_pkg::*;
#(
    parameter int W       = 8,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   ch_mask,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    input  logic [NCH-1:0]   ch_ready,
    output logic [NCH-1:0]   ch_valid,
    output logic [W-1:0]     ch_data,
    output logic [1:0]       sel,
    output logic             en,
    output logic             busy,
    output logic [CNT_W-1:0] skip_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT);

    state_t            r_state;
    state_t            w_state_next;
    logic [W-1:0]      r_buf;
    grant_t            r_sel;
    grant_t            r_last;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_skip;

    grant_t            w_pick_idx;
    logic              w_pick_found;
    logic              w_grant_ready;
    logic              w_timeout;

    rr_pick4 u_pick (
        .mask  (ch_mask),
        .last  (r_last),
        .idx   (w_pick_idx),
        .found (w_pick_found)
    );

    // Only the granted channel's ready matters; others are ignored.
    assign w_grant_ready = ch_ready[r_sel];
    // Wait counter starts at 0 on entry to XFER, so reaching TIMEOUT-1 means
    // the channel has been offered the word for TIMEOUT cycles.
    assign w_timeout     = (r_wait == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        en           = 1'b0;
        busy         = 1'b1;
        ch_valid     = '0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_next = ARB;
                end
            end
            ARB: begin
                if (w_pick_found) begin
                    w_state_next = XFER;
                end
            end
            XFER: begin
                en           = 1'b1;
                ch_valid     = NCH'(1) << r_sel;
                if (w_grant_ready) begin
                    w_state_next = IDLE;
                end else if (w_timeout) begin
                    w_state_next = ARB;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf  <= '0;
            r_sel  <= '0;
            r_last <= 2'd3;
            r_wait <= '0;
            r_skip <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_buf <= in_data;
                    end
                end
                ARB: begin
                    if (w_pick_found) begin
                        r_sel  <= w_pick_idx;
                        r_wait <= '0;
                    end
                end
                XFER: begin
                    if (w_grant_ready) begin
                        r_last <= r_sel;
                    end else if (w_timeout) begin
                        r_last <= r_sel;
                        if (r_skip != {CNT_W{1'b1}}) begin
                            r_skip <= r_skip + 1'b1;
                        end
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ch_data  = r_buf;
    assign sel      = r_sel;
    assign skip_cnt = r_skip;

endmodule : demux_rr_scheduler
`default_nettype wire

// File: tb/tb_demux_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_rr_scheduler
//  Purpose  : Self-checking bench for demux_rr_scheduler: vector table for
//             grant order, directed multi-cycle corner cases, and randomized
//             traffic compared against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_demux_rr_scheduler;

    localparam int W       = 8;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       ch_mask;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             in_ready;
    logic [3:0]       ch_ready;
    logic [3:0]       ch_valid;
    logic [W-1:0]     ch_data;
    logic [1:0]       sel;
    logic             en;
    logic             busy;
    logic [CNT_W-1:0] skip_cnt;

    int n_checks = 0;
    int n_err    = 0;

    demux_rr_scheduler #(.W(W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch_mask  (ch_mask),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .ch_ready (ch_ready),
        .ch_valid (ch_valid),
        .ch_data  (ch_data),
        .sel      (sel),
        .en       (en),
        .busy     (busy),
        .skip_cnt (skip_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic       rst_before;
        logic [3:0] mask;
        logic [7:0] data;
        int         exp_ch;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        ch_mask  = 4'hF;
        ch_ready = 4'hF;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge. Presents one word, checks the ARB cycle and the
    // grant cycle (2 cycles after acceptance). Returns at the grant negedge.
    task automatic send_word(input logic [7:0] data, input int exp_ch);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("send_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
        check("arb_ch_valid", 32'(ch_valid), 32'd0);
        check("arb_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("grant_ch_valid", 32'(ch_valid), 32'd1 << exp_ch);
        check("grant_data", 32'(ch_data), 32'(data));
        check("grant_sel", 32'(sel), 32'(exp_ch));
        check("grant_en", 32'(en), 32'd1);
    endtask

    function automatic int rr_expect(input logic [3:0] m, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (m[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    int cnt;
    int seen;
    int bad;

    // Reference model: phase 0 = waiting for word, 1 = choosing channel,
    // 2 = word offered to m_ch for m_age cycles so far.
    int         m_phase;
    int         m_last;
    int         m_ch;
    int         m_age;
    int         m_skip;
    logic [7:0] m_word;
    int         pick;

    initial begin
        vecs[0] = '{1'b1, 4'hF, 8'hA1, 0};
        vecs[1] = '{1'b0, 4'hF, 8'hA2, 1};
        vecs[2] = '{1'b0, 4'hF, 8'hA3, 2};
        vecs[3] = '{1'b0, 4'hF, 8'hA4, 3};
        vecs[4] = '{1'b0, 4'hF, 8'hA5, 0};
        vecs[5] = '{1'b1, 4'b0101, 8'hB1, 0};
        vecs[6] = '{1'b0, 4'b0101, 8'hB2, 2};
        vecs[7] = '{1'b0, 4'b0101, 8'hB3, 0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        ch_mask  = 4'hF;
        ch_ready = 4'hF;
        do_reset();

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_en", 32'(en), 32'd0);
        check("rst_ch_valid", 32'(ch_valid), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_skip", 32'(skip_cnt), 32'd0);
        check("rst_ch_data", 32'(ch_data), 32'd0);

        // Grant-order vectors
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].rst_before) do_reset();
            ch_mask  = vecs[i].mask;
            ch_ready = 4'hF;
            send_word(vecs[i].data, vecs[i].exp_ch);
            @(negedge clk);
            check("vec_done_in_ready", 32'(in_ready), 32'd1);
        end

        // Stalled channel times out after TIMEOUT cycles, word moves on
        do_reset();
        send_word(8'h10, 0);
        @(negedge clk);
        ch_ready = 4'b1101;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ch_valid == 4'b0010) cnt++;
            else if (cnt > 0) break;
        end
        check("to_valid_cycles", 32'(cnt), 32'(TIMEOUT));
        check("to_skip_cnt", 32'(skip_cnt), 32'd1);
        check("to_rearb_valid", 32'(ch_valid), 32'd0);
        @(negedge clk);
        check("to_next_ch_valid", 32'(ch_valid), 32'b0100);
        check("to_next_data", 32'(ch_data), 32'h3C);
        @(negedge clk);
        check("to_done_in_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset in the middle of a transfer
        ch_ready = 4'h0;
        send_word(8'h5A, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ch_valid", 32'(ch_valid), 32'd0);
        check("arst_en", 32'(en), 32'd0);
        check("arst_skip", 32'(skip_cnt), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n    = 1'b1;
        ch_ready = 4'hF;
        send_word(8'h66, 0);
        @(negedge clk);

        // Empty mask holds the word in arbitration
        ch_mask  = 4'h0;
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(negedge clk);
        in_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy !== 1'b1 || in_ready !== 1'b0 || ch_valid !== 4'h0) bad++;
            @(negedge clk);
        end
        check("hold_arb_bad_cycles", 32'(bad), 32'd0);
        ch_mask = 4'b1000;
        @(negedge clk);
        check("hold_release_valid", 32'(ch_valid), 32'b1000);
        check("hold_release_data", 32'(ch_data), 32'h77);

        // Skip counter saturation with a single permanently stalled channel
        do_reset();
        ch_mask  = 4'b0010;
        ch_ready = 4'h0;
        send_word(8'hA5, 1);
        for (int i = 0; i < 5000; i++) begin
            if (skip_cnt == {CNT_W{1'b1}}) break;
            @(negedge clk);
        end
        check("sat_reached", 32'(skip_cnt), 32'd255);
        seen = 0;
        bad  = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ch_valid == 4'b0010 && ch_data == 8'hA5) seen++;
            else if (ch_valid != 4'b0000) bad++;
        end
        check("sat_hold", 32'(skip_cnt), 32'd255);
        check("sat_word_stays_ch1", 32'(seen > 0 && bad == 0), 32'd1);

        // Randomized traffic against reference model
        do_reset();
        m_phase = 0;
        m_last  = 3;
        m_ch    = 0;
        m_age   = 0;
        m_skip  = 0;
        m_word  = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            check("rnd_in_ready", 32'(in_ready), 32'(m_phase == 0));
            check("rnd_busy", 32'(busy), 32'(m_phase != 0));
            check("rnd_en", 32'(en), 32'(m_phase == 2));
            check("rnd_ch_valid", 32'(ch_valid), (m_phase == 2) ? (32'd1 << m_ch) : 32'd0);
            check("rnd_sel", 32'(sel), 32'(m_ch));
            check("rnd_skip", 32'(skip_cnt), 32'(m_skip));
            if (m_phase == 2) check("rnd_data", 32'(ch_data), 32'(m_word));

            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            ch_mask  = 4'($urandom_range(0, 15));
            for (int b = 0; b < 4; b++) begin
                if ((cyc / 150) % 2 == 1) ch_ready[b] = ($urandom_range(0, 7) == 0);
                else                      ch_ready[b] = ($urandom_range(0, 1) == 0);
            end

            case (m_phase)
                0: if (in_valid) begin
                    m_word  = in_data;
                    m_phase = 1;
                end
                1: begin
                    pick = rr_expect(ch_mask, m_last);
                    if (pick >= 0) begin
                        m_ch    = pick;
                        m_age   = 0;
                        m_phase = 2;
                    end
                end
                default: begin
                    if (ch_ready[m_ch]) begin
                        m_last  = m_ch;
                        m_phase = 0;
                    end else if (m_age == TIMEOUT - 1) begin
                        m_last  = m_ch;
                        m_skip  = (m_skip < 255) ? m_skip + 1 : 255;
                        m_phase = 1;
                    end else begin
                        m_age++;
                    end
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_demux_rr_scheduler
`default_nettype wire
